// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator.
// Divides the system clock down to the pixel rate, scans an H_TOTAL x V_TOTAL
// frame and presents hsync/vsync/video_on/pix_x/pix_y from one register stage,
// together with one-clk p_tick, line_start and frame_start pulses.
// Optional feature: define VGA_SYNC_GAME_TICK_EN to build the frame counter
// and the game_tick pulse; without it game_tick is tied low.
// All counters are 10 bits wide, so H_TOTAL and V_TOTAL must not exceed 1024.
module vga_sync_gen #(
  parameter int CLK_DIV          = 2,
  parameter int H_DISPLAY        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_DISPLAY        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int GAME_TICK_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       p_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       game_tick
);

  // Line and frame geometry derived from the porch/sync lengths.
  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // The divider needs at least one bit even when every clk is a pixel.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Region comparisons are done at 11 bits so a boundary of exactly 1024
  // cannot alias to zero.
  localparam logic [10:0] H_DISP_B  = 11'(H_DISPLAY);
  localparam logic [10:0] H_SYNC_SB = 11'(H_SYNC_START);
  localparam logic [10:0] H_SYNC_EB = 11'(H_SYNC_END);
  localparam logic [10:0] V_DISP_B  = 11'(V_DISPLAY);
  localparam logic [10:0] V_SYNC_SB = 11'(V_SYNC_START);
  localparam logic [10:0] V_SYNC_EB = 11'(V_SYNC_END);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    H_ACT,
    H_FP,
    H_SYN,
    H_BP
  } hState_t;

  typedef enum logic [1:0] {
    V_ACT,
    V_FP,
    V_SYN,
    V_BP
  } vState_t;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hCnt;
  logic [9:0]       r_vCnt;

  logic    w_tick;
  logic    w_hWrap;
  logic    w_vWrap;
  logic    w_atOrigin;
  logic    w_lineOrigin;
  hState_t w_hState;
  vState_t w_vState;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_hWrap      = (r_hCnt == H_LAST);
  assign w_vWrap      = (r_vCnt == V_LAST);
  assign w_lineOrigin = (r_hCnt == 10'd0);
  assign w_atOrigin   = w_lineOrigin && (r_vCnt == 10'd0);

  // Pixel-rate divider: counts 0..CLK_DIV-1 and marks the last count as the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Horizontal region decode: the state is a pure function of the column.
  always_comb begin
    w_hState = H_BP;
    if ({1'b0, r_hCnt} < H_DISP_B) begin
      w_hState = H_ACT;
    end else if ({1'b0, r_hCnt} < H_SYNC_SB) begin
      w_hState = H_FP;
    end else if ({1'b0, r_hCnt} < H_SYNC_EB) begin
      w_hState = H_SYN;
    end
  end

  // Vertical region decode: only moves when the line counter moves.
  always_comb begin
    w_vState = V_BP;
    if ({1'b0, r_vCnt} < V_DISP_B) begin
      w_vState = V_ACT;
    end else if ({1'b0, r_vCnt} < V_SYNC_SB) begin
      w_vState = V_FP;
    end else if ({1'b0, r_vCnt} < V_SYNC_EB) begin
      w_vState = V_SYN;
    end
  end

  // Scan counters: column advances each tick, line advances on a column wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_tick) begin
      if (w_hWrap) begin
        r_hCnt <= '0;
        if (w_vWrap) begin
          r_vCnt <= '0;
        end else begin
          r_vCnt <= r_vCnt + 10'd1;
        end
      end else begin
        r_hCnt <= r_hCnt + 10'd1;
      end
    end
  end

  // Output stage: captures the decode of the current counters so every port
  // describes the same pixel; the pulses are high for the clk after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x       <= '0;
      pix_y       <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      p_tick      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      p_tick      <= w_tick;
      line_start  <= w_tick && w_lineOrigin;
      frame_start <= w_tick && w_atOrigin;
      if (w_tick) begin
        pix_x    <= r_hCnt;
        pix_y    <= r_vCnt;
        video_on <= (w_hState == H_ACT) && (w_vState == V_ACT);
        hsync    <= (w_hState != H_SYN);
        vsync    <= (w_vState != V_SYN);
      end
    end
  end

`ifdef VGA_SYNC_GAME_TICK_EN
  localparam logic [7:0] FRAME_LAST = 8'(GAME_TICK_FRAMES - 1);

  logic [7:0] r_frameCnt;

  // Frame counter: steps on every frame start and fires game_tick on the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
      game_tick  <= 1'b0;
    end else begin
      game_tick <= 1'b0;
      if (w_tick && w_atOrigin) begin
        if (r_frameCnt == FRAME_LAST) begin
          r_frameCnt <= '0;
          game_tick  <= 1'b1;
        end else begin
          r_frameCnt <= r_frameCnt + 8'd1;
        end
      end
    end
  end
`else
  // No frame counter in this build; the frame count has no effect and the
  // pulse is tied low whatever its value.
  if (GAME_TICK_FRAMES > 0) begin : g_noGameTick
    assign game_tick = 1'b0;
  end else begin : g_noGameTickBadCount
    assign game_tick = 1'b0;
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized-reset bench for vga_sync_gen with a reduced
// frame geometry; expected outputs are computed from the pixel index since
// reset release using plain division/modulo arithmetic.
module tb_vga_sync_gen;

  localparam int DIV = 2;
  localparam int HD  = 20;
  localparam int HF  = 3;
  localparam int HS  = 4;
  localparam int HB  = 3;
  localparam int VD  = 12;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int NF  = 4;
  localparam int HT  = HD + HF + HS + HB;
  localparam int VT  = VD + VF + VS + VB;
  localparam int FT  = HT * VT;

`ifdef VGA_SYNC_GAME_TICK_EN
  localparam bit GT_EN = 1'b1;
`else
  localparam bit GT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       p_tick;
  logic       line_start;
  logic       frame_start;
  logic       game_tick;

  int total = 0;
  int bad = 0;

  vga_sync_gen #(
    .CLK_DIV(DIV),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .GAME_TICK_FRAMES(NF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .p_tick(p_tick),
    .line_start(line_start),
    .frame_start(frame_start),
    .game_tick(game_tick)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // All ports at their reset values.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, " pix_x"}, 32'(pix_x), 0);
    checkOutput({tag, " pix_y"}, 32'(pix_y), 0);
    checkOutput({tag, " video_on"}, 32'(video_on), 0);
    checkOutput({tag, " hsync"}, 32'(hsync), 1);
    checkOutput({tag, " vsync"}, 32'(vsync), 1);
    checkOutput({tag, " p_tick"}, 32'(p_tick), 0);
    checkOutput({tag, " line_start"}, 32'(line_start), 0);
    checkOutput({tag, " frame_start"}, 32'(frame_start), 0);
    checkOutput({tag, " game_tick"}, 32'(game_tick), 0);
  endtask

  // Reference model: after clk edge e (1-based since release) the outputs
  // show pixel k = e/DIV - 1, and the pulses are high only on edges that are
  // multiples of DIV.
  task automatic checkPixel(input int e);
    bit tickNow;
    int k, x, y, frame;
    int expVon, expHs, expVs, expLs, expFs, expGt;
    tickNow = (e % DIV) == 0;
    checkOutput("p_tick", 32'(p_tick), 32'(tickNow));
    if (e < DIV) begin
      checkResetValues("pre-tick");
    end else begin
      k      = e / DIV - 1;
      x      = k % HT;
      y      = (k / HT) % VT;
      frame  = k / FT;
      expVon = (x < HD && y < VD) ? 1 : 0;
      expHs  = (x >= HD + HF && x < HD + HF + HS) ? 0 : 1;
      expVs  = (y >= VD + VF && y < VD + VF + VS) ? 0 : 1;
      expLs  = (tickNow && x == 0) ? 1 : 0;
      expFs  = (tickNow && (k % FT) == 0) ? 1 : 0;
      expGt  = (GT_EN && expFs == 1 && (frame % NF) == NF - 1) ? 1 : 0;
      checkOutput("pix_x", 32'(pix_x), 32'(x));
      checkOutput("pix_y", 32'(pix_y), 32'(y));
      checkOutput("video_on", 32'(video_on), 32'(expVon));
      checkOutput("hsync", 32'(hsync), 32'(expHs));
      checkOutput("vsync", 32'(vsync), 32'(expVs));
      checkOutput("line_start", 32'(line_start), 32'(expLs));
      checkOutput("frame_start", 32'(frame_start), 32'(expFs));
      checkOutput("game_tick", 32'(game_tick), 32'(expGt));
    end
  endtask

  // Run a number of clk edges after a release, checking each one #1 later.
  task automatic applyStimulus(input int cycles);
    for (int e = 1; e <= cycles; e++) begin
      @(posedge clk);
      #1;
      checkPixel(e);
    end
  endtask

  // Mid-frame reset between clock edges: outputs must clear without an edge,
  // stay cleared while held, and the release lands on a falling edge.
  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    checkResetValues("held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("init");
    @(negedge clk);
    rst_n = 1'b1;
    // Long enough to cover two full game-tick periods and many frame wraps.
    applyStimulus(2 * NF * FT * DIV + 57);
    for (int s = 0; s < 4; s++) begin
      pulseReset();
      applyStimulus($urandom_range(500, 9000));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator: divides the system clock to a pixel rate, scans horizontal and vertical counters over a full 800×525 frame, and drives `hsync`, `vsync`, `video_on` and `pix_x`/`pix_y`. It is the upstream end of the pixel-coordinate interface. The graphics block consumes `video_on` and `pix_x`/`pix_y` and returns RGB; `hsync`/`vsync` go directly to the connector. An optional per-N-frame game tick replaces free-running move counters.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (≥1).
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `GAME_TICK_FRAMES`, 6: frames per `game_tick`, range 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `video_on`  out  1  high while (`pix_x`,`pix_y`) is in the visible area.
- `pix_x`  out  10  current column.
- `pix_y`  out  10  current line.
- `p_tick`  out  1  one-clk pulse marking each new pixel on the outputs.
- `line_start`  out  1  one-clk pulse with `p_tick` when `pix_x`==0.
- `frame_start`  out  1  one-clk pulse with `p_tick` when `pix_x`==0 and `pix_y`==0.
- `game_tick`  out  1  one-clk pulse every `GAME_TICK_FRAMES` frames.

## Operation
- **Divider.** The divider counts 0..`CLK_DIV`-1 and wraps. The internal tick asserts when the divider is at `CLK_DIV`-1. With `CLK_DIV`=1, the tick is high every cycle.
- **Totals.** H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525). Both totals must be ≤1024; the design is 10-bit throughout.
- **Horizontal FSM.** States H_ACT → H_FP → H_SYN → H_BP → H_ACT. Each state lasts its parameter length in pixels. The state is decoded from `h_cnt`.
- **Vertical FSM.** States V_ACT → V_FP → V_SYN → V_BP → V_ACT. It advances only when `h_cnt` wraps from H_TOTAL-1 to 0.
- **Per internal tick:**
  - The output registers capture the decode of the current (`h_cnt`,`v_cnt`).
  - `h_cnt` then increments, wrapping at H_TOTAL-1.
  - On an `h_cnt` wrap, `v_cnt` increments, wrapping at V_TOTAL-1.
- **Decode:**
  - `pix_x`=`h_cnt`, `pix_y`=`v_cnt`.
  - `video_on` = `h_cnt`<H_DISPLAY && `v_cnt`<V_DISPLAY.
  - `hsync` is low for `h_cnt` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - `vsync` is low for `v_cnt` in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], across the entire line.
- **Output consistency.** All outputs come from a single register stage. `pix_x`, `pix_y`, `video_on`, `hsync` and `vsync` always describe the same pixel.
- **Frame counter.** The frame counter (8 bits) increments on each `frame_start` and wraps at `GAME_TICK_FRAMES`-1. `game_tick` pulses together with the `frame_start` at which the counter wraps.

## Timing
- **Reset values (immediate on `rst_n` low, asynchronous):**
  - Divider, `h_cnt`, `v_cnt` and frame counter are 0.
  - `pix_x`=0, `pix_y`=0.
  - `hsync`=1, `vsync`=1.
  - `video_on`=0.
  - `p_tick`, `line_start`, `frame_start`, `game_tick` are 0.
- **After reset release:** the first internal tick occurs on clk edge `CLK_DIV` after release. At that edge the outputs show (0,0), `video_on`=1, and `frame_start`, `line_start`, `p_tick` are all 1 for that cycle.
- **Pulse alignment.** `p_tick` is high in the clk cycle immediately after the output registers update. Downstream logic samples outputs on `p_tick`. Outputs are stable for `CLK_DIV` clks.
- **Latency.** Internal counters lead the outputs by one pixel. No combinational path exists from the counters to the ports.
- **Wrap-around.** After (799,524), the next pixel is (0,0) with `frame_start`.
- **Simultaneous events.** `frame_start` implies `line_start`. `game_tick` implies `frame_start`. All three are asserted in the same cycle.
- **Reset mid-frame.** Reset aborts the scan immediately. The scan restarts from (0,0) as above, and the frame counter restarts at 0.

## Configuration
- **`VGA_SYNC_GAME_TICK_EN` defined:** the frame counter and `game_tick` are built as described above.
- **`VGA_SYNC_GAME_TICK_EN` undefined:** no frame counter is synthesized, `game_tick` is tied to 0, and `GAME_TICK_FRAMES` is ignored.

## Test plan
All scenarios use defaults at `CLK_DIV`=2.
- **Reset release:** release reset → first `p_tick` at clk 2 after release, with `frame_start`=1, `pix_x`=0, `pix_y`=0, `video_on`=1, `hsync`=`vsync`=1. Consecutive `p_tick`s are 2 clks apart.
- **Line timing:** scan one line →
  - `video_on` falls at `pix_x`=640.
  - `hsync` is low for `pix_x` 656..751, exactly 96 `p_tick`s.
  - `line_start` repeats every 1600 clks.
- **Frame timing:** scan a frame →
  - `vsync` is low for all of lines 490..491, i.e. 1600 `p_tick`s.
  - `video_on` is 0 for every pixel on lines 480..524.
  - `frame_start` repeats every 840,000 clks.
- **Wrap-around:** observe the end of frame → (799,524) is followed by (0,0) with `frame_start`=`line_start`=1. `pix_x`/`pix_y` never exceed 799/524.
- **Game tick:** with the macro defined, `game_tick` fires every 6th `frame_start`, i.e. every 5,040,000 clks, coincident with `frame_start`. With the macro undefined, `game_tick` stays 0 over 7 frames.
- **Mid-frame reset:** assert `rst_n` low at (300,200) → outputs go to reset values in the same cycle without waiting for clk. After release, the scan resumes at (0,0) and the next `game_tick` comes 6 frames later.
